single_softmax_arbiter: RTL and testbench
=========================================

Name: single_softmax_arbiter

Overview:
- Round-robin arbiter that shares one single_softmax_v datapath among NREQ requesters.
- Accepts at most one vector job per cycle and issues it to the pipelined softmax with a start pulse.
- Tracks the owner of every in-flight job in an ordered tag FIFO, and routes each done result back to the requester that issued it.
- Sits between the layer sequencers and the softmax unit.

Parameters:
- WIDTH, 8: vector length, 32-bit IEEE single elements; passed unchanged to the softmax unit.
- NREQ, 4: number of requesters, 2..16.
- MAX_INFLIGHT, 4: maximum outstanding jobs in the softmax pipeline; power of two, at least 1; sets the tag FIFO depth.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester job request; held until granted.
- req_vector  input  [31:0] x [NREQ][WIDTH]  per-requester input vector; stable while req is high.
- gnt  output  NREQ  one-hot, combinational; gnt[i] high means job i is accepted this cycle.
- sm_start  output  1  registered start pulse to the softmax unit.
- sm_vector_a  output  [31:0] x [WIDTH]  registered vector to the softmax unit.
- sm_done  input  1  done pulse from the softmax unit.
- sm_vector_c  input  [31:0] x [WIDTH]  softmax result, valid with sm_done.
- rsp_valid  output  NREQ  one-hot one-cycle response pulse.
- rsp_vector  output  [31:0] x [WIDTH]  result vector, shared by all requesters, valid with rsp_valid.
- inflight  output  $clog2(MAX_INFLIGHT)+1  number of outstanding jobs.
- err  output  1  sticky protocol error.

Behaviour:
- Reset values (async, rstn low): gnt=0, sm_start=0, sm_vector_a all 0, rsp_valid=0, rsp_vector all 0, inflight=0, err=0, rr_ptr=0, tag FIFO empty (rd/wr pointers 0).
- Arbitration, combinational:
  - can_issue = (inflight < MAX_INFLIGHT).
  - If can_issue and any req is high, grant the first set bit scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NREQ.
  - gnt = 0 when can_issue is 0.
- Issue, on the clock edge after gnt[i]:
  - sm_start=1 for exactly one cycle; sm_vector_a = req_vector[i] latched.
  - Push i into the tag FIFO.
  - rr_ptr = (i+1) mod NREQ.
  - With no grant, sm_start=0 and sm_vector_a holds its value.
- Requester rule: drop req the cycle after it sees gnt, or keep it high to queue the next job. Back-to-back grants to one requester happen only when no other req is pending.
- Latency: gnt to sm_start is 1 cycle; sm_done to rsp_valid is 1 cycle. Total is 2 cycles plus the softmax latency.
- Completion, on sm_done:
  - Pop the FIFO head id.
  - Next cycle: rsp_valid[id]=1 and rsp_vector = sm_vector_c registered.
  - rsp_vector holds between pulses.
- inflight:
  - +1 on issue, -1 on a valid pop.
  - Issue and pop in the same cycle: unchanged, FIFO push and pop both happen.
  - Full case: when inflight==MAX_INFLIGHT and sm_done arrives, the freed slot is usable from the next cycle only. gnt uses the registered inflight; no same-cycle bypass.
- Ordering: results return in issue order, since the softmax pipeline is in-order; the FIFO relies on this.
- Error: sm_done with the FIFO empty sets err, which stays set until reset; no rsp_valid, no pointer change.
- Pointer wrap: FIFO pointers wrap modulo MAX_INFLIGHT. inflight distinguishes full from empty.
- Reset mid-operation: all state clears immediately. The softmax unit shares rstn, so no stale done pulses arrive; in-flight jobs are lost and requesters must re-request.
- NREQ=1 degenerate case: gnt = req & can_issue.

Decomposition:
- Package single_softmax_pkg:
  - localparam ID_W = $clog2(NREQ) (min 1).
  - localparam CNT_W = $clog2(MAX_INFLIGHT)+1.
  - function rr_pick(req, ptr), returning the one-hot grant.
- Sub-module tag_fifo (params DEPTH, DATA_W): push, pop, head, count; registered storage, async active-low reset.
- Top module contains the arbiter, the issue registers, the response registers, err, and the single_softmax_v port wiring.

Test Plan:
- Single job: req=0001, vector of 1.0 x8 -> gnt=0001 same cycle; sm_start 1 cycle later. After the softmax done, rsp_valid=0001 with every element 0x3E000000 (0.125).
- Round-robin: req=1111 held for 4 grants -> gnt sequence 0001, 0010, 0100, 1000. rsp_valid pulses arrive in the same order with the matching vectors ([0,1,...,7] per-requester offsets verified against the reference model).
- Full throttle: MAX_INFLIGHT=4, softmax stalled so no done -> 4 grants, then gnt=0 and inflight=4. One sm_done -> inflight=3, and the next grant appears the following cycle.
- Simultaneous issue and done at inflight=2 -> inflight stays 2; head id returned; new id queued at the tail.
- Spurious sm_done with inflight=0 -> err=1 and stays 1; rsp_valid stays 0; a following normal job still completes correctly.
- Reset asserted with 3 jobs in flight -> all outputs 0 and inflight=0 within the reset. After release, a new job from requester 2 gets gnt=0100, since rr_ptr=0 and only req[2] is high.

Source files
------------

// File: rtl/single_softmax_pkg.sv
// Shared helpers for the softmax arbiter: width helpers and the round-robin pick.
package single_softmax_pkg;

  localparam int NREQ_MAX         = 16;
  localparam int DEF_NREQ         = 4;
  localparam int DEF_MAX_INFLIGHT = 4;

  typedef logic [NREQ_MAX-1:0] req_vec_t;

  // Width of a requester id; a single requester still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int ID_W  = id_width(DEF_NREQ);
  localparam int CNT_W = cnt_width(DEF_MAX_INFLIGHT);

  // One-hot grant of the first requesting bit at or after ptr, wrapping modulo n.
  function automatic req_vec_t rr_pick(input req_vec_t req, input int ptr, input int n);
    req_vec_t                      g;
    logic                          found;
    logic [$clog2(NREQ_MAX)-1:0]   idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ_MAX; k++) begin
      idx = ($clog2(NREQ_MAX))'((ptr + k) % n);
      if ((k < n) && !found && req[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/tag_fifo.sv
// Ordered owner-id FIFO: one entry per job in the softmax pipeline, oldest at head.
module tag_fifo
  import single_softmax_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 2
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        push,
  input  logic                        pop,
  input  logic [DATA_W-1:0]           din,
  output logic [DATA_W-1:0]           head,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = cnt_width(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CW-1:0]     r_count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // Pointers and occupancy; push and pop in one cycle leave the count unchanged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (push && !pop)      r_count <= r_count + 1'b1;
      else if (pop && !push) r_count <= r_count - 1'b1;
    end
  end

  // Storage is data only; occupancy decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= din;
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/single_softmax_arbiter.sv
// Round-robin front end sharing one softmax datapath among NREQ requesters,
// with in-order result routing through a tag FIFO.
module single_softmax_arbiter
  import single_softmax_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int NREQ         = 4,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [NREQ-1:0]                  req,
  input  logic [NREQ*WIDTH*32-1:0]         req_vector,
  output logic [NREQ-1:0]                  gnt,
  output logic                             sm_start,
  output logic [WIDTH*32-1:0]              sm_vector_a,
  input  logic                             sm_done,
  input  logic [WIDTH*32-1:0]              sm_vector_c,
  output logic [NREQ-1:0]                  rsp_valid,
  output logic [WIDTH*32-1:0]              rsp_vector,
  output logic [$clog2(MAX_INFLIGHT):0]    inflight,
  output logic                             err
);

  localparam int VW  = WIDTH * 32;
  localparam int IDW = id_width(NREQ);
  localparam int CW  = $clog2(MAX_INFLIGHT) + 1;

  logic [IDW-1:0]      r_rr_ptr;
  logic                r_sm_start_p1;
  logic [VW-1:0]       r_sm_vector_p1;
  logic [NREQ-1:0]     r_rsp_valid_p1;
  logic [VW-1:0]       r_rsp_vector_p1;
  logic                r_err;

  logic                w_can_issue;
  logic                w_issue;
  logic                w_pop;
  logic                w_spurious;
  req_vec_t            w_pick;
  logic [NREQ-1:0]     w_gnt;
  logic [IDW-1:0]      w_gnt_id;
  logic [IDW-1:0]      w_next_ptr;
  logic [IDW-1:0]      w_head;
  logic [NREQ-1:0]     w_head_onehot;
  logic [CW-1:0]       w_count;
  logic [VW-1:0]       w_sel_vector;

  // The registered occupancy gates new grants; a slot freed by sm_done opens next cycle.
  assign w_can_issue = (int'(w_count) < MAX_INFLIGHT);
  assign w_pick      = rr_pick(req_vec_t'(req), int'(r_rr_ptr), NREQ);
  assign w_gnt       = w_can_issue ? w_pick[NREQ-1:0] : '0;
  assign w_issue     = |w_gnt;
  assign w_next_ptr  = (int'(w_gnt_id) == NREQ - 1) ? '0 : w_gnt_id + 1'b1;

  assign w_pop         = sm_done && (w_count != '0);
  assign w_spurious    = sm_done && (w_count == '0);
  assign w_head_onehot = NREQ'(1) << w_head;

  // Encode the grant and select the winning requester's vector.
  always_comb begin
    w_gnt_id     = '0;
    w_sel_vector = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_gnt_id     = IDW'(i);
        w_sel_vector = req_vector[i*VW +: VW];
      end
    end
  end

  tag_fifo #(
    .DEPTH  (MAX_INFLIGHT),
    .DATA_W (IDW)
  ) u_tag_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (w_issue),
    .pop   (w_pop),
    .din   (w_gnt_id),
    .head  (w_head),
    .count (w_count)
  );

  // Issue stage: one-cycle start pulse, latched vector, pointer moves past the winner.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sm_start_p1  <= 1'b0;
      r_sm_vector_p1 <= '0;
      r_rr_ptr       <= '0;
    end else begin
      r_sm_start_p1 <= w_issue;
      if (w_issue) begin
        r_sm_vector_p1 <= w_sel_vector;
        r_rr_ptr       <= w_next_ptr;
      end
    end
  end

  // Response stage: route the result to the oldest owner; a done with no owner is sticky error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rsp_valid_p1  <= '0;
      r_rsp_vector_p1 <= '0;
      r_err           <= 1'b0;
    end else begin
      r_rsp_valid_p1 <= w_pop ? w_head_onehot : '0;
      if (w_pop)      r_rsp_vector_p1 <= sm_vector_c;
      if (w_spurious) r_err           <= 1'b1;
    end
  end

  assign gnt         = w_gnt;
  assign sm_start    = r_sm_start_p1;
  assign sm_vector_a = r_sm_vector_p1;
  assign rsp_valid   = r_rsp_valid_p1;
  assign rsp_vector  = r_rsp_vector_p1;
  assign inflight    = w_count;
  assign err         = r_err;

endmodule

// File: tb/tb_single_softmax_arbiter.sv
// Self-checking bench: requester queues, a behavioural softmax stand-in and an
// issue-order scoreboard.
module tb_single_softmax_arbiter;

  localparam int WIDTH        = 8;
  localparam int NREQ         = 4;
  localparam int MAX_INFLIGHT = 4;
  localparam int VW           = WIDTH * 32;
  localparam int LAT          = 3;
  localparam int BIG          = 1000000;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*VW-1:0]   req_vector = '0;
  logic [NREQ-1:0]      gnt;
  logic                 sm_start;
  logic [VW-1:0]        sm_vector_a;
  logic                 sm_done = 1'b0;
  logic [VW-1:0]        sm_vector_c = '0;
  logic [NREQ-1:0]      rsp_valid;
  logic [VW-1:0]        rsp_vector;
  logic [2:0]           inflight;
  logic                 err;

  int checks = 0;
  int errors = 0;

  single_softmax_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_vector(req_vector), .gnt(gnt),
    .sm_start(sm_start), .sm_vector_a(sm_vector_a), .sm_done(sm_done),
    .sm_vector_c(sm_vector_c), .rsp_valid(rsp_valid), .rsp_vector(rsp_vector),
    .inflight(inflight), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Softmax stand-in: a constant vector maps to the uniform 1/8; anything else to a keyed scramble.
  function automatic logic [VW-1:0] sm_ref(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    logic          uni;
    uni = 1'b1;
    for (int k = 0; k < WIDTH; k++) if (v[k*32 +: 32] != v[31:0]) uni = 1'b0;
    for (int k = 0; k < WIDTH; k++)
      r[k*32 +: 32] = uni ? 32'h3E00_0000 : ((v[k*32 +: 32] ^ 32'h3C00_0000) + 32'(k));
    return r;
  endfunction

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] v;
    logic [31:0]   x;
    x = $urandom;
    for (int k = 0; k < WIDTH; k++) v[k*32 +: 32] = ($urandom_range(0, 3) == 0) ? x : $urandom;
    return v;
  endfunction

  // Softmax unit model with fixed latency, done budget and optional random stalls.
  typedef struct { logic [VW-1:0] v; int due; } job_t;
  job_t smq[$];
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_budget = BIG;
  bit   force_done = 1'b0;
  bit   rand_stall = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      smq.delete();
      sm_done = 1'b0;
    end else begin
      if (sm_start) smq.push_back('{v: sm_vector_a, due: cyc + LAT});
      sm_done = 1'b0;
      if (force_done) begin
        sm_done     = 1'b1;
        sm_vector_c = {8{$urandom}};
      end else if (smq.size() > 0 && smq[0].due <= cyc && done_budget > 0 &&
                   !(rand_stall && $urandom_range(0, 2) == 0)) begin
        sm_done     = 1'b1;
        sm_vector_c = sm_ref(smq[0].v);
        void'(smq.pop_front());
        done_budget--;
        done_cnt++;
      end
    end
  end

  // Response log.
  logic [NREQ-1:0] rsp_log_id[$];
  logic [VW-1:0]   rsp_log_v[$];
  always @(negedge clk) begin
    if (rstn && rsp_valid != '0) begin
      rsp_log_id.push_back(rsp_valid);
      rsp_log_v.push_back(rsp_vector);
    end
  end

  // Requester model and issue scoreboard.
  typedef struct { int id; logic [VW-1:0] v; } iss_t;
  iss_t            exp_iss[$];
  logic [VW-1:0]   pend_mem [NREQ][16];
  int              pend_hd [NREQ];
  int              pend_tl [NREQ];
  int              issue_cnt = 0;
  int              rr_m = 0;
  int              infl_m = 0;
  logic [NREQ-1:0] exp_g, got_g;

  task automatic add_job(input int r, input logic [VW-1:0] v);
    pend_mem[r][pend_tl[r] % 16] = v;
    pend_tl[r]++;
  endtask

  function automatic int pend_total();
    int t;
    t = 0;
    for (int i = 0; i < NREQ; i++) t += pend_tl[i] - pend_hd[i];
    return t;
  endfunction

  task automatic clear_logs();
    exp_iss.delete();
    rsp_log_id.delete();
    rsp_log_v.delete();
  endtask

  // One cycle: present pending jobs, predict the grant (closest requester at or after
  // the pointer, only while fewer than MAX_INFLIGHT jobs are outstanding), record it.
  task automatic advance();
    int best;
    int d, dbest;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      req[i] = (pend_tl[i] != pend_hd[i]);
      req_vector[i*VW +: VW] = req[i] ? pend_mem[i][pend_hd[i] % 16] : '0;
    end
    #1;
    infl_m = issue_cnt - done_cnt;
    best   = -1;
    dbest  = NREQ;
    if (infl_m < MAX_INFLIGHT) begin
      for (int r = 0; r < NREQ; r++) begin
        d = (r - rr_m + NREQ) % NREQ;
        if (req[r] && d < dbest) begin
          best  = r;
          dbest = d;
        end
      end
    end
    exp_g = (best >= 0) ? NREQ'(1 << best) : '0;
    got_g = gnt;
    if (best >= 0) begin
      exp_iss.push_back('{id: best, v: pend_mem[best][pend_hd[best] % 16]});
      pend_hd[best]++;
      rr_m = (best + 1) % NREQ;
      issue_cnt++;
    end
  endtask

  task automatic wait_drain(output bit to);
    to = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      advance();
      if (pend_total() == 0 && issue_cnt == done_cnt && rsp_log_id.size() >= exp_iss.size()) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    req  = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({gnt, sm_start, rsp_valid, inflight, err} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: gnt=%b start=%b rsp_valid=%b inflight=%0d err=%b, required all 0", gnt, sm_start, rsp_valid, inflight, err);
    end
    checks++;
    if ({sm_vector_a, rsp_vector} !== '0) begin
      errors++;
      $display("FAIL reset_data: sm_vector_a=%h rsp_vector=%h, required 0", sm_vector_a, rsp_vector);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] seq [4];
    bit to;
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int r = 0; r < NREQ; r++) begin
      logic [VW-1:0] v;
      for (int k = 0; k < WIDTH; k++) v[k*32 +: 32] = 32'h4000_0000 | 32'((r * WIDTH + k) << 12);
      add_job(r, v);
    end
    for (int s = 0; s < 4; s++) begin
      advance();
      checks++;
      if (got_g !== seq[s]) begin
        errors++;
        $display("FAIL rr_gnt[%0d]: got %b, required %b", s, got_g, seq[s]);
      end
    end
    wait_drain(to);
    checks++;
    if (to || rsp_log_id.size() != exp_iss.size()) begin
      errors++;
      $display("FAIL rr_drain: got %0d responses, required %0d", rsp_log_id.size(), exp_iss.size());
    end
    for (int k = 0; k < exp_iss.size() && k < rsp_log_id.size(); k++) begin
      checks++;
      if (rsp_log_id[k] !== NREQ'(1 << exp_iss[k].id) || rsp_log_v[k] !== sm_ref(exp_iss[k].v)) begin
        errors++;
        $display("FAIL rr_rsp[%0d]: got %b %h, required %b %h", k, rsp_log_id[k], rsp_log_v[k], NREQ'(1 << exp_iss[k].id), sm_ref(exp_iss[k].v));
      end
    end
    clear_logs();
  endtask

  task automatic test_single();
    bit to;
    add_job(0, {8{32'h3F80_0000}});
    advance();
    checks++;
    if (got_g !== 4'b0001) begin
      errors++;
      $display("FAIL single_gnt: got %b, required 0001", got_g);
    end
    advance();
    checks++;
    if (sm_start !== 1'b1 || sm_vector_a !== {8{32'h3F80_0000}}) begin
      errors++;
      $display("FAIL single_start: got start=%b vec=%h, required 1 and all 3f800000", sm_start, sm_vector_a);
    end
    advance();
    checks++;
    if (sm_start !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse: start=%b one cycle later, required 0", sm_start);
    end
    wait_drain(to);
    checks++;
    if (to || rsp_log_id.size() != 1) begin
      errors++;
      $display("FAIL single_drain: got %0d responses, required 1", rsp_log_id.size());
    end else begin
      checks++;
      if (rsp_log_id[0] !== 4'b0001 || rsp_log_v[0] !== {8{32'h3E00_0000}}) begin
        errors++;
        $display("FAIL single_rsp: got %b %h, required 0001 all 3e000000", rsp_log_id[0], rsp_log_v[0]);
      end
    end
    clear_logs();
  endtask

  task automatic test_full();
    bit to;
    done_budget = 0;
    for (int r = 0; r < NREQ; r++) add_job(r, rnd_vec());
    add_job(0, rnd_vec());
    for (int s = 0; s < 4; s++) begin
      advance();
      checks++;
      if (got_g !== exp_g || got_g == '0) begin
        errors++;
        $display("FAIL full_gnt[%0d]: got %b, required %b", s, got_g, exp_g);
      end
    end
    repeat (2) begin
      advance();
      checks++;
      if (got_g !== '0 || inflight !== 3'd4) begin
        errors++;
        $display("FAIL full_block: gnt=%b inflight=%0d, required 0000 and 4", got_g, inflight);
      end
    end
    done_budget = 1;
    @(negedge clk);
    #1;
    checks++;
    if (sm_done !== 1'b1 || gnt !== '0) begin
      errors++;
      $display("FAIL full_nobypass: done=%b gnt=%b, required 1 and 0000", sm_done, gnt);
    end
    advance();
    checks++;
    if (inflight !== 3'd3 || got_g !== exp_g || got_g == '0) begin
      errors++;
      $display("FAIL full_reopen: inflight=%0d gnt=%b, required 3 and %b", inflight, got_g, exp_g);
    end
    done_budget = BIG;
    wait_drain(to);
    checks++;
    if (to || rsp_log_id.size() != exp_iss.size()) begin
      errors++;
      $display("FAIL full_drain: got %0d responses, required %0d", rsp_log_id.size(), exp_iss.size());
    end
    for (int k = 0; k < exp_iss.size() && k < rsp_log_id.size(); k++) begin
      checks++;
      if (rsp_log_id[k] !== NREQ'(1 << exp_iss[k].id) || rsp_log_v[k] !== sm_ref(exp_iss[k].v)) begin
        errors++;
        $display("FAIL full_rsp[%0d]: got %b %h, required %b %h", k, rsp_log_id[k], rsp_log_v[k], NREQ'(1 << exp_iss[k].id), sm_ref(exp_iss[k].v));
      end
    end
    clear_logs();
  endtask

  task automatic test_simul();
    bit to;
    done_budget = 0;
    add_job(0, rnd_vec());
    add_job(1, rnd_vec());
    repeat (LAT + 4) advance();
    checks++;
    if (inflight !== 3'd2) begin
      errors++;
      $display("FAIL simul_setup: inflight=%0d, required 2", inflight);
    end
    add_job(2, rnd_vec());
    advance();
    done_budget = 1;
    checks++;
    if (got_g !== 4'b0100) begin
      errors++;
      $display("FAIL simul_gnt: got %b, required 0100", got_g);
    end
    advance();
    checks++;
    if (inflight !== 3'd2 || rsp_valid !== NREQ'(1 << exp_iss[0].id)) begin
      errors++;
      $display("FAIL simul_both: inflight=%0d rsp_valid=%b, required 2 and %b", inflight, rsp_valid, NREQ'(1 << exp_iss[0].id));
    end
    done_budget = BIG;
    wait_drain(to);
    checks++;
    if (to || rsp_log_id.size() != 3) begin
      errors++;
      $display("FAIL simul_drain: got %0d responses, required 3", rsp_log_id.size());
    end
    for (int k = 0; k < exp_iss.size() && k < rsp_log_id.size(); k++) begin
      checks++;
      if (rsp_log_id[k] !== NREQ'(1 << exp_iss[k].id) || rsp_log_v[k] !== sm_ref(exp_iss[k].v)) begin
        errors++;
        $display("FAIL simul_rsp[%0d]: got %b %h, required %b %h", k, rsp_log_id[k], rsp_log_v[k], NREQ'(1 << exp_iss[k].id), sm_ref(exp_iss[k].v));
      end
    end
    clear_logs();
  endtask

  task automatic test_spurious();
    bit to;
    logic [VW-1:0] v;
    advance();
    force_done = 1'b1;
    @(negedge clk);
    #1;
    force_done = 1'b0;
    advance();
    checks++;
    if (err !== 1'b1 || rsp_valid !== '0 || inflight !== 3'd0) begin
      errors++;
      $display("FAIL spur_err: err=%b rsp_valid=%b inflight=%0d, required 1, 0000, 0", err, rsp_valid, inflight);
    end
    v = rnd_vec();
    add_job(3, v);
    wait_drain(to);
    checks++;
    if (to || rsp_log_id.size() != 1) begin
      errors++;
      $display("FAIL spur_drain: got %0d responses, required 1", rsp_log_id.size());
    end else begin
      checks++;
      if (rsp_log_id[0] !== 4'b1000 || rsp_log_v[0] !== sm_ref(v)) begin
        errors++;
        $display("FAIL spur_rsp: got %b %h, required 1000 %h", rsp_log_id[0], rsp_log_v[0], sm_ref(v));
      end
    end
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL spur_sticky: err=%b, required 1", err);
    end
    clear_logs();
  endtask

  task automatic test_reset_midflight();
    bit to;
    logic [VW-1:0] v;
    done_budget = 0;
    add_job(0, rnd_vec());
    add_job(1, rnd_vec());
    add_job(3, rnd_vec());
    repeat (4) advance();
    checks++;
    if (inflight !== 3'd3) begin
      errors++;
      $display("FAIL rstmid_setup: inflight=%0d, required 3", inflight);
    end
    req  = '0;
    rstn = 1'b0;
    #1;
    checks++;
    if ({gnt, sm_start, rsp_valid, inflight, err} !== '0 || {sm_vector_a, rsp_vector} !== '0) begin
      errors++;
      $display("FAIL rstmid_clear: gnt=%b start=%b rsp_valid=%b inflight=%0d err=%b vec_a=%h rsp=%h, required all 0", gnt, sm_start, rsp_valid, inflight, err, sm_vector_a, rsp_vector);
    end
    issue_cnt = 0;
    rr_m      = 0;
    clear_logs();
    repeat (2) @(posedge clk);
    done_cnt = 0;
    @(negedge clk);
    rstn        = 1'b1;
    done_budget = BIG;
    v = rnd_vec();
    add_job(2, v);
    advance();
    checks++;
    if (got_g !== 4'b0100) begin
      errors++;
      $display("FAIL rstmid_gnt: got %b, required 0100", got_g);
    end
    wait_drain(to);
    checks++;
    if (to || rsp_log_id.size() != 1 || rsp_log_id[0] !== 4'b0100 || rsp_log_v[0] !== sm_ref(v)) begin
      errors++;
      $display("FAIL rstmid_rsp: got %0d responses, required one 0100 response with %h", rsp_log_id.size(), sm_ref(v));
    end
    clear_logs();
  endtask

  task automatic test_random();
    bit to;
    int r;
    rand_stall = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 1) == 0) begin
        r = $urandom_range(0, NREQ - 1);
        if (pend_tl[r] - pend_hd[r] < 8) add_job(r, rnd_vec());
      end
      advance();
      checks++;
      if (got_g !== exp_g || inflight !== 3'(infl_m)) begin
        errors++;
        $display("FAIL rand_cycle[%0d]: gnt=%b inflight=%0d, required %b and %0d", c, got_g, inflight, exp_g, infl_m);
      end
    end
    wait_drain(to);
    rand_stall = 1'b0;
    checks++;
    if (to || rsp_log_id.size() != exp_iss.size()) begin
      errors++;
      $display("FAIL rand_drain: got %0d responses, required %0d", rsp_log_id.size(), exp_iss.size());
    end
    for (int k = 0; k < exp_iss.size() && k < rsp_log_id.size(); k++) begin
      checks++;
      if (rsp_log_id[k] !== NREQ'(1 << exp_iss[k].id) || rsp_log_v[k] !== sm_ref(exp_iss[k].v)) begin
        errors++;
        $display("FAIL rand_rsp[%0d]: got %b %h, required %b %h", k, rsp_log_id[k], rsp_log_v[k], NREQ'(1 << exp_iss[k].id), sm_ref(exp_iss[k].v));
      end
    end
    clear_logs();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_full();
    test_simul();
    test_spurious();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
